// File: rtl/expand_nucleotides_stream_if.sv
// Stream bundle for the nucleotide expander: packed-read input side and ASCII beat output side.
// master = the surrounding fabric (read source and byte sink), slave = the expander.
interface expand_nucleotides_stream_if #(
   parameter int LENGTH = 64,
   parameter int BYTES  = 8
);
   localparam int LENW = $clog2(LENGTH + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [2*LENGTH-1:0]   in_read;
   logic [LENW-1:0]       in_len;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*BYTES-1:0]    out_data;
   logic [BYTES-1:0]      out_keep;
   logic                  out_last;

   modport master (
      output in_valid, in_read, in_len, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_read, in_len, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/expand_nucleotides_stream.sv
// Expands one 2-bit packed read into ASCII bases, BYTES per beat, with keep/last framing.
//
// state | meaning
// IDLE  | no read held, in_ready=1, waiting for in_valid
// SEND  | read captured, beat registers valid, out_valid=1
module expand_nucleotides_stream #(
   parameter int LENGTH = 64,
   parameter int BYTES  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   expand_nucleotides_stream_if.slave    s,
   output logic                          len_err
);
   localparam int LENW  = $clog2(LENGTH + 1);
   localparam int NBMAX = (LENGTH + BYTES - 1) / BYTES;
   localparam int BW    = $clog2(NBMAX + 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [2*LENGTH-1:0]  read_q;
   logic [LENW-1:0]      len_q;
   logic [BW-1:0]        beat_q;

   logic                 load, done, bad_len;
   logic [LENW-1:0]      len_eff;
   logic [2*LENGTH-1:0]  src_read;
   logic [LENW-1:0]      src_len;
   logic [BW-1:0]        src_beat;
   logic [8*BYTES-1:0]   nxt_data;
   logic [BYTES-1:0]     nxt_keep;
   logic                 nxt_last;
   int                   idx;

   function automatic logic [7:0] to_ascii(input logic [1:0] b);
      logic [7:0] c;
      case (b)
         2'b00:   c = 8'd65;
         2'b01:   c = 8'd67;
         2'b10:   c = 8'd71;
         default: c = 8'd84;
      endcase
      return c;
   endfunction

   assign done    = s.out_valid & s.out_ready;
   assign load    = s.in_valid & s.in_ready;
   assign bad_len = (s.in_len == '0) || (s.in_len > LENW'(LENGTH));
   assign len_eff = bad_len ? LENW'(LENGTH) : s.in_len;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (load) state_d = SEND;
         SEND: if (done && s.out_last && !s.in_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s.in_ready  = 1'b0;
      s.out_valid = 1'b0;
      case (state_q)
         IDLE: s.in_ready = 1'b1;
         SEND: begin
            s.out_valid = 1'b1;
            s.in_ready  = s.out_ready & s.out_last;
         end
         default: ;
      endcase
   end

   // Next beat comes either from a read being accepted now or from the held read.
   always_comb begin
      if (load) begin
         src_read = s.in_read;
         src_len  = len_eff;
         src_beat = '0;
      end else begin
         src_read = read_q;
         src_len  = len_q;
         src_beat = beat_q + 1'b1;
      end
   end

   always_comb begin
      idx      = 0;
      nxt_data = '0;
      nxt_keep = '0;
      for (int j = 0; j < BYTES; j++) begin
         idx = int'(src_beat) * BYTES + j;
         if (idx < int'(src_len)) begin
            nxt_keep[j]         = 1'b1;
            nxt_data[8*j +: 8]  = to_ascii(src_read[2*idx +: 2]);
         end
      end
      nxt_last = ((int'(src_beat) + 1) * BYTES) >= int'(src_len);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         s.out_data <= '0;
         s.out_keep <= '0;
         s.out_last <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         len_err <= load & bad_len;
         if (load) begin
            read_q <= s.in_read;
            len_q  <= len_eff;
         end
         if (load || (done && !s.out_last)) begin
            beat_q     <= src_beat;
            s.out_data <= nxt_data;
            s.out_keep <= nxt_keep;
            s.out_last <= nxt_last;
         end else if (done) begin
            beat_q     <= '0;
            s.out_data <= '0;
            s.out_keep <= '0;
            s.out_last <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_expand_nucleotides_stream.sv
// Directed-vector bench for expand_nucleotides_stream at LENGTH=8, BYTES=4.
module tb_expand_nucleotides_stream;
   localparam int LENGTH = 8;
   localparam int BYTES  = 4;

   typedef struct {
      logic [15:0] rd;
      logic [3:0]  len;
      int          nb;
      logic [31:0] d0, d1;
      logic [3:0]  k0, k1;
      logic        err;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic len_err;
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[8];

   always #5 clk = ~clk;

   expand_nucleotides_stream_if #(.LENGTH(LENGTH), .BYTES(BYTES)) ifc ();

   expand_nucleotides_stream #(.LENGTH(LENGTH), .BYTES(BYTES)) dut (
      .clk     (clk),
      .rst     (rst),
      .s       (ifc.slave),
      .len_err (len_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] asc(input logic [1:0] b);
      logic [7:0] c;
      case (b)
         2'b00:   c = 8'h41;
         2'b01:   c = 8'h43;
         2'b10:   c = 8'h47;
         default: c = 8'h54;
      endcase
      return c;
   endfunction

   function automatic void model_beat(input logic [15:0] rd, input int len, input int b,
                                      output beat_t e);
      e = '0;
      for (int j = 0; j < BYTES; j++) begin
         int i = b * BYTES + j;
         if (i < len) begin
            e.k[j]        = 1'b1;
            e.d[8*j +: 8] = asc(rd[2*i +: 2]);
         end
      end
      e.l = ((b + 1) * BYTES) >= len;
   endfunction

   // Entered and left at a sample point with the DUT idle.
   task automatic run_vec(input vec_t v, input string tag);
      ifc.in_valid  = 1'b1;
      ifc.in_read   = v.rd;
      ifc.in_len    = v.len;
      ifc.out_ready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'(1'b1));
      step();
      ifc.in_valid = 1'b0;
      ifc.in_read  = '0;
      chk({tag, "_len_err"}, 64'(len_err), 64'(v.err));
      for (int b = 0; b < v.nb; b++) begin
         chk({tag, "_valid"}, 64'(ifc.out_valid), 64'(1'b1));
         chk({tag, "_data"},  64'(ifc.out_data),  64'(b == 0 ? v.d0 : v.d1));
         chk({tag, "_keep"},  64'(ifc.out_keep),  64'(b == 0 ? v.k0 : v.k1));
         chk({tag, "_last"},  64'(ifc.out_last),  64'(b == v.nb - 1));
         step();
         if (b == 0) chk({tag, "_len_err_once"}, 64'(len_err), 64'(1'b0));
      end
      chk({tag, "_idle_after"}, 64'(ifc.out_valid), 64'(1'b0));
   endtask

   initial begin
      beat_t       expq[$];
      beat_t       e, held;
      logic [15:0] rds[100];
      int          lns[100];
      int          rd_idx, got, total;
      logic        stalled;

      vecs[0] = '{rd:16'hE4E4, len:4'd8,  nb:2, d0:32'h54474341, d1:32'h54474341, k0:4'hF, k1:4'hF, err:1'b0};
      vecs[1] = '{rd:16'hE4E4, len:4'd5,  nb:2, d0:32'h54474341, d1:32'h00000041, k0:4'hF, k1:4'h1, err:1'b0};
      vecs[2] = '{rd:16'hE4E4, len:4'd0,  nb:2, d0:32'h54474341, d1:32'h54474341, k0:4'hF, k1:4'hF, err:1'b1};
      vecs[3] = '{rd:16'hE4E4, len:4'd9,  nb:2, d0:32'h54474341, d1:32'h54474341, k0:4'hF, k1:4'hF, err:1'b1};
      vecs[4] = '{rd:16'h1B1B, len:4'd4,  nb:1, d0:32'h41434754, d1:32'h0,        k0:4'hF, k1:4'h0, err:1'b0};
      vecs[5] = '{rd:16'h0000, len:4'd1,  nb:1, d0:32'h00000041, d1:32'h0,        k0:4'h1, k1:4'h0, err:1'b0};
      vecs[6] = '{rd:16'hFF00, len:4'd7,  nb:2, d0:32'h41414141, d1:32'h00545454, k0:4'hF, k1:4'h7, err:1'b0};
      vecs[7] = '{rd:16'h1B1B, len:4'd15, nb:2, d0:32'h41434754, d1:32'h41434754, k0:4'hF, k1:4'hF, err:1'b1};

      ifc.in_valid  = 1'b0;
      ifc.in_read   = '0;
      ifc.in_len    = '0;
      ifc.out_ready = 1'b0;

      // Reset state
      #3;
      chk("rst_valid", 64'(ifc.out_valid), 64'(1'b0));
      chk("rst_regs", 64'({ifc.out_data, ifc.out_keep, ifc.out_last}), 64'(0));
      chk("rst_len_err", 64'(len_err), 64'(1'b0));
      step();
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 64'(ifc.in_ready), 64'(1'b1));
      step();

      for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Back-to-back reads with in_valid held high
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      ifc.in_read   = 16'hE4E4;
      ifc.in_len    = 4'd8;
      step();
      ifc.in_read = 16'h1B1B;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) ifc.in_valid = 1'b0;
         #1;
         chk("b2b_valid", 64'(ifc.out_valid), 64'(1'b1));
         chk("b2b_last", 64'(ifc.out_last), 64'(k % 2));
         chk("b2b_in_ready", 64'(ifc.in_ready), 64'(k % 2));
         chk("b2b_data", 64'(ifc.out_data), 64'(k < 2 ? 32'h54474341 : 32'h41434754));
         step();
      end
      chk("b2b_idle", 64'(ifc.out_valid), 64'(1'b0));

      // Reset during beat1
      ifc.in_valid = 1'b1;
      ifc.in_read  = 16'hE4E4;
      ifc.in_len   = 4'd8;
      step();
      ifc.in_valid = 1'b0;
      step();
      chk("mid_beat1_last", 64'(ifc.out_last), 64'(1'b1));
      ifc.out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(ifc.out_valid), 64'(1'b0));
      chk("mid_rst_regs", 64'({ifc.out_data, ifc.out_keep, ifc.out_last}), 64'(0));
      step();
      step();
      rst = 1'b0;
      ifc.out_ready = 1'b1;
      #1;
      chk("mid_rel_in_ready", 64'(ifc.in_ready), 64'(1'b1));
      step();
      chk("mid_no_stale0", 64'(ifc.out_valid), 64'(1'b0));
      step();
      chk("mid_no_stale1", 64'(ifc.out_valid), 64'(1'b0));
      run_vec(vecs[4], "post_rst");

      // Random backpressure over 100 reads against the reference decode
      for (int i = 0; i < 100; i++) begin
         int eff, nb;
         rds[i] = 16'($urandom);
         lns[i] = int'($urandom_range(0, 10));
         eff = (lns[i] == 0 || lns[i] > LENGTH) ? LENGTH : lns[i];
         nb  = (eff + BYTES - 1) / BYTES;
         for (int b = 0; b < nb; b++) begin
            model_beat(rds[i], eff, b, e);
            expq.push_back(e);
         end
      end
      total   = expq.size();
      rd_idx  = 0;
      got     = 0;
      stalled = 1'b0;
      held    = '0;
      for (int cyc = 0; cyc < 5000 && got < total; cyc++) begin
         if (stalled)
            chk("stall_hold", 64'({ifc.out_valid, ifc.out_data, ifc.out_keep, ifc.out_last}),
                64'({1'b1, held}));
         ifc.out_ready = 1'($urandom_range(0, 1));
         ifc.in_valid  = (rd_idx < 100) && ($urandom_range(0, 3) != 0);
         ifc.in_read   = rds[rd_idx < 100 ? rd_idx : 99];
         ifc.in_len    = 4'(lns[rd_idx < 100 ? rd_idx : 99]);
         #1;
         if (ifc.in_valid && ifc.in_ready) rd_idx++;
         if (ifc.out_valid && ifc.out_ready) begin
            chk("stream_expected", 64'(expq.size() > 0), 64'(1'b1));
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("stream_beat", 64'({ifc.out_data, ifc.out_keep, ifc.out_last}), 64'(e));
            end
            got++;
         end
         stalled = ifc.out_valid && !ifc.out_ready;
         held    = {ifc.out_data, ifc.out_keep, ifc.out_last};
         step();
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      chk("stream_count", 64'(got), 64'(total));
      chk("stream_reads", 64'(rd_idx), 64'(100));
      step();
      chk("stream_no_extra", 64'(ifc.out_valid), 64'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
